// File: rtl/writer_if.sv
// writer_if: parallel-load / serial-out handshake bundle for the writer.
//   slave  modport (writer side): load, din, enable, abort in;
//                                 mosi, ready, busy, done, bits_left out.
//   master modport (producer side): the mirror image.
//   width : word length in bits; bits_left is clog2(width+1) bits wide.
interface writer_if #(
  parameter int width = 64
);
  logic                         load;
  logic [width-1:0]             din;
  logic                         enable;
  logic                         abort;
  logic                         mosi;
  logic                         ready;
  logic                         busy;
  logic                         done;
  logic [$clog2(width+1)-1:0]   bits_left;

  modport master (
    output load, din, enable, abort,
    input  mosi, ready, busy, done, bits_left
  );

  modport slave (
    input  load, din, enable, abort,
    output mosi, ready, busy, done, bits_left
  );
endinterface

// File: rtl/writer.sv
// writer: parallel-in, serial-out shift register (SPI-style transmit side).
//   sclk     : shift clock, all state changes on posedge
//   clear_n  : asynchronous active-low clear
//   bus      : writer_if.slave
//     load/din   capture a word while ready (IDLE)
//     enable     shift qualifier shared with the paired reader
//     abort      synchronous cancel of the word in flight
//     mosi       MSB of the shift register while busy, 0 when idle
//     ready/busy IDLE / SHIFT indication, always complementary
//     done       registered one-cycle pulse after the last bit
//     bits_left  bits of the current word not yet consumed
// The word leaves MSB first; mosi is valid in the cycle right after the
// load edge, so the reader samples bit width-1 on the first enabled edge.
module writer #(
  parameter int width = 64
) (
  input  logic     sclk,
  input  logic     clear_n,
  writer_if.slave  bus
);

  localparam int CW = $clog2(width + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [width-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    left_q,  left_d;
  logic             done_q,  done_d;

  always_ff @(posedge sclk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      left_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      left_q  <= left_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    left_d  = left_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // enable and abort are meaningless here; load alone starts a word
        if (bus.load) begin
          shreg_d = bus.din;
          left_d  = CW'(width);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // abort outranks enable; load is never sampled while shifting
        if (bus.abort) begin
          shreg_d = '0;
          left_d  = '0;
          state_d = IDLE;
        end else if (bus.enable) begin
          shreg_d = {shreg_q[width-2:0], 1'b0};
          if (left_q == CW'(1)) begin
            left_d  = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            left_d  = left_q - CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy      = (state_q == SHIFT);
  assign bus.ready     = (state_q == IDLE);
  assign bus.mosi      = shreg_q[width-1] & bus.busy;
  assign bus.done      = done_q;
  assign bus.bits_left = left_q;

endmodule

// File: tb/tb_writer.sv
// tb_writer: self-checking bench for writer with two instances (width 8
// and width 64), a paired serial reader per instance, and a word-level
// reference model compared on every falling edge.
module tb_writer;

  logic sclk    = 1'b0;
  logic clear_n = 1'b1;

  always #5 sclk = ~sclk;

  writer_if #(.width(8))  if8  ();
  writer_if #(.width(64)) if64 ();

  writer #(.width(8))  dut8  (.sclk(sclk), .clear_n(clear_n), .bus(if8));
  writer #(.width(64)) dut64 (.sclk(sclk), .clear_n(clear_n), .bus(if64));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level model: a word is either in flight (with 'sent' bits already
  // consumed) or not. Outputs are derived from that, not from a shift reg.
  typedef struct {
    bit           busy;
    logic [255:0] word;
    int           sent;
    bit           done;
  } mdl_t;

  mdl_t m8  = '{busy: 1'b0, word: '0, sent: 0, done: 1'b0};
  mdl_t m64 = '{busy: 1'b0, word: '0, sent: 0, done: 1'b0};

  function automatic mdl_t step(mdl_t m, int w, bit ld, logic [255:0] d, bit en, bit ab);
    mdl_t n = m;
    n.done = 1'b0;
    if (!m.busy) begin
      if (ld) begin
        n.busy = 1'b1;
        n.word = d;
        n.sent = 0;
      end
    end else if (ab) begin
      n.busy = 1'b0;
      n.sent = 0;
    end else if (en) begin
      n.sent = m.sent + 1;
      if (n.sent == w) begin
        n.busy = 1'b0;
        n.sent = 0;
        n.done = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic mdl_t mreset();
    mdl_t n;
    n.busy = 1'b0;
    n.word = '0;
    n.sent = 0;
    n.done = 1'b0;
    return n;
  endfunction

  always @(posedge sclk or negedge clear_n) begin
    if (!clear_n) begin
      m8  = mreset();
      m64 = mreset();
    end else begin
      m8  = step(m8, 8, if8.load, {248'd0, if8.din}, if8.enable, if8.abort);
      m64 = step(m64, 64, if64.load, {192'd0, if64.din}, if64.enable, if64.abort);
    end
  end

  // Paired readers: shift mosi in on every enabled edge.
  logic [7:0]  rd8  = '0;
  logic [63:0] rd64 = '0;
  always @(posedge sclk) begin
    if (if8.enable)  rd8  <= {rd8[6:0], if8.mosi};
    if (if64.enable) rd64 <= {rd64[62:0], if64.mosi};
  end

  int done8_cnt  = 0;
  int done64_cnt = 0;

  always @(negedge sclk) begin
    chk("w8_mosi",  {63'd0, if8.mosi},  m8.busy ? {63'd0, m8.word[7 - m8.sent]} : 64'd0);
    chk("w8_ready", {63'd0, if8.ready}, {63'd0, ~m8.busy});
    chk("w8_busy",  {63'd0, if8.busy},  {63'd0, m8.busy});
    chk("w8_done",  {63'd0, if8.done},  {63'd0, m8.done});
    chk("w8_left",  {60'd0, if8.bits_left}, m8.busy ? 64'(8 - m8.sent) : 64'd0);
    chk("w64_mosi",  {63'd0, if64.mosi},  m64.busy ? {63'd0, m64.word[63 - m64.sent]} : 64'd0);
    chk("w64_ready", {63'd0, if64.ready}, {63'd0, ~m64.busy});
    chk("w64_busy",  {63'd0, if64.busy},  {63'd0, m64.busy});
    chk("w64_done",  {63'd0, if64.done},  {63'd0, m64.done});
    chk("w64_left",  {57'd0, if64.bits_left}, m64.busy ? 64'(64 - m64.sent) : 64'd0);
    if (m8.done)  chk("w8_reader",  {56'd0, rd8}, m8.word[63:0] & 64'hFF);
    if (m64.done) chk("w64_reader", rd64, m64.word[63:0]);
    if (if8.done)  done8_cnt++;
    if (if64.done) done64_cnt++;
  end

  task automatic idle_inputs();
    if8.load = 0;  if8.din = '0;  if8.enable = 0;  if8.abort = 0;
    if64.load = 0; if64.din = '0; if64.enable = 0; if64.abort = 0;
  endtask

  task automatic wait_done8(input string name);
    for (int i = 0; i < 200 && !if8.done; i++) @(negedge sclk);
    chk(name, {63'd0, if8.done}, 64'd1);
  endtask

  int          d0, cnt;
  logic        seq [0:63];
  logic [3:0]  exp_left [0:10];
  logic        pat [0:10];

  initial begin
    idle_inputs();
    clear_n = 1'b0;
    repeat (2) @(negedge sclk);
    chk("rst_ready", {63'd0, if8.ready}, 64'd1);
    chk("rst_left",  {60'd0, if8.bits_left}, 64'd0);
    chk("rst_mosi",  {63'd0, if64.mosi}, 64'd0);
    clear_n = 1'b1;

    // 1: idle with enable toggling
    d0 = done8_cnt;
    for (int i = 0; i < 10; i++) begin
      if8.enable = i[0];
      if8.abort  = (i == 4);
      @(negedge sclk);
    end
    chk("idle_no_done", 64'(done8_cnt - d0), 64'd0);
    chk("idle_busy", {63'd0, if8.busy}, 64'd0);
    idle_inputs();

    // 2: single 64-bit word, continuous enable
    if64.load = 1; if64.din = 64'hDEADBEEF_01234567;
    @(negedge sclk);
    cnt = 1;
    chk("w64_load_left", {57'd0, if64.bits_left}, 64'd64);
    if64.load = 0; if64.enable = 1;
    for (int i = 0; i < 64; i++) seq[i] = 1'b0;
    seq[0] = if64.mosi;
    for (int i = 1; i < 200 && !if64.done; i++) begin
      @(negedge sclk);
      cnt++;
      if (if64.busy && i < 64) seq[i] = if64.mosi;
    end
    chk("w64_seq0", {63'd0, seq[0]}, 64'd1);
    chk("w64_seq1", {63'd0, seq[1]}, 64'd1);
    chk("w64_seq2", {63'd0, seq[2]}, 64'd0);
    chk("w64_seq3", {63'd0, seq[3]}, 64'd1);
    chk("w64_latency", 64'(cnt), 64'd65);
    chk("w64_dout", rd64, 64'hDEADBEEF_01234567);
    chk("w64_done_ready", {63'd0, if64.ready}, 64'd1);
    idle_inputs();
    @(negedge sclk);

    // 3: stalls
    pat = '{1,0,0,1,1,0,1,1,1,1,1};
    exp_left = '{4'd7,4'd7,4'd7,4'd6,4'd5,4'd5,4'd4,4'd3,4'd2,4'd1,4'd0};
    if8.load = 1; if8.din = 8'hA5;
    @(negedge sclk);
    if8.load = 0;
    chk("stall_load_left", {60'd0, if8.bits_left}, 64'd8);
    for (int i = 0; i < 11; i++) begin
      if8.enable = pat[i];
      @(negedge sclk);
      chk("stall_left", {60'd0, if8.bits_left}, {60'd0, exp_left[i]});
    end
    chk("stall_done", {63'd0, if8.done}, 64'd1);
    chk("stall_dout", {56'd0, rd8}, 64'hA5);
    idle_inputs();
    @(negedge sclk);

    // 4: load ignored while busy, then back-to-back
    if8.load = 1; if8.din = 8'h3C;
    @(negedge sclk);
    if8.load = 0; if8.enable = 1;
    repeat (3) @(negedge sclk);
    if8.load = 1; if8.din = 8'hFF;
    @(negedge sclk);
    if8.load = 0;
    wait_done8("b2b_done1");
    chk("b2b_dout1", {56'd0, rd8}, 64'h3C);
    if8.load = 1; if8.din = 8'hC3;
    @(negedge sclk);
    if8.load = 0;
    chk("b2b_busy2", {63'd0, if8.busy}, 64'd1);
    chk("b2b_left2", {60'd0, if8.bits_left}, 64'd8);
    wait_done8("b2b_done2");
    chk("b2b_dout2", {56'd0, rd8}, 64'hC3);
    idle_inputs();
    @(negedge sclk);

    // 5: abort after 3 enabled edges, abort together with enable
    d0 = done8_cnt;
    if8.load = 1; if8.din = 8'hF0;
    @(negedge sclk);
    if8.load = 0; if8.enable = 1;
    repeat (3) @(negedge sclk);
    if8.abort = 1;
    @(negedge sclk);
    if8.abort = 0;
    chk("abort_ready", {63'd0, if8.ready}, 64'd1);
    chk("abort_mosi",  {63'd0, if8.mosi}, 64'd0);
    chk("abort_left",  {60'd0, if8.bits_left}, 64'd0);
    repeat (10) @(negedge sclk);
    chk("abort_no_done", 64'(done8_cnt - d0), 64'd0);
    idle_inputs();

    // 6: asynchronous clear mid-word
    if8.load = 1; if8.din = 8'hFF;
    @(negedge sclk);
    if8.load = 0; if8.enable = 1;
    repeat (2) @(negedge sclk);
    d0 = done8_cnt;
    @(posedge sclk);
    #2 clear_n = 1'b0;
    #1;
    chk("arst_busy",  {63'd0, if8.busy}, 64'd0);
    chk("arst_ready", {63'd0, if8.ready}, 64'd1);
    chk("arst_mosi",  {63'd0, if8.mosi}, 64'd0);
    chk("arst_left",  {60'd0, if8.bits_left}, 64'd0);
    @(negedge sclk);
    clear_n = 1'b1;
    repeat (12) @(negedge sclk);
    chk("arst_no_done", 64'(done8_cnt - d0), 64'd0);
    idle_inputs();

    // Random traffic on both instances against the model
    for (int i = 0; i < 3000; i++) begin
      if8.load   = ($urandom_range(0, 3) == 0);
      if8.din    = 8'($urandom);
      if8.enable = ($urandom_range(0, 3) != 0);
      if8.abort  = ($urandom_range(0, 29) == 0);
      if64.load   = ($urandom_range(0, 3) == 0);
      if64.din    = {$urandom, $urandom};
      if64.enable = ($urandom_range(0, 4) != 0);
      if64.abort  = ($urandom_range(0, 199) == 0);
      if (i % 997 == 500) begin
        @(posedge sclk);
        #2 clear_n = 1'b0;
        @(negedge sclk);
        clear_n = 1'b1;
      end else begin
        @(negedge sclk);
      end
    end
    idle_inputs();
    @(negedge sclk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
